// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one syncram port between two requesters with one-cycle read return
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_BURST  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic          last_gnt, rd_pend, rd_port, pick1, any_gnt;
  logic [BW-1:0] burst_cnt;
  // pick1 only matters on a tie: alternate in RR, otherwise yield to p1 once the burst cap is hit
  assign pick1       = (FIXED_PRIO != 0) ? (burst_cnt == BW'(MAX_BURST)) : !last_gnt;
  assign p0_gnt      = !reset && p0_req && !(p1_req && pick1);
  assign p1_gnt      = !reset && p1_req && !(p0_req && !pick1);
  assign any_gnt     = p0_gnt || p1_gnt;
  assign mem_address = p0_gnt ? p0_addr : p1_gnt ? p1_addr : '0;
  assign mem_data    = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
  assign mem_wren    = p0_gnt ? p0_wren : (p1_gnt && p1_wren);
  // reset gates rvalid so a read in flight when reset arrives is never reported
  assign p0_rvalid   = !reset && rd_pend && !rd_port;
  assign p1_rvalid   = !reset && rd_pend && rd_port;
  assign p0_rdata    = p0_rvalid ? mem_q : '0;
  assign p1_rdata    = p1_rvalid ? mem_q : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
    end else begin
      if (any_gnt) last_gnt <= p1_gnt;
      burst_cnt <= (FIXED_PRIO == 0 || p1_gnt || !p1_req) ? '0 :
                   (p0_gnt && burst_cnt != BW'(MAX_BURST)) ? burst_cnt + BW'(1) : burst_cnt;
      rd_pend   <= any_gnt && !mem_wren;
      rd_port   <= p1_gnt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of round-robin and fixed-priority arbiters over a syncram model
module tb_dmem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        p0_req = 0, p0_wren = 0, p1_req = 0, p1_wren = 0;
  logic [11:0] p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic        r_p0_gnt, r_p0_rvalid, r_p1_gnt, r_p1_rvalid, r_wren;
  logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid, f_wren;
  logic [31:0] r_p0_rdata, r_p1_rdata, r_data, r_q, f_p0_rdata, f_p1_rdata, f_data, f_q;
  logic [11:0] r_addr, f_addr, r_aq, f_aq;
  logic [31:0] r_mem [4096];
  logic [31:0] f_mem [4096];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return (a == 16) ? 32'hDEADBEEF : (32'h5A5A0000 ^ 32'(a));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) begin
        r_mem[i] <= init_word(i);
        f_mem[i] <= init_word(i);
      end
    end else begin
      if (r_wren) r_mem[r_addr] <= r_data;
      if (f_wren) f_mem[f_addr] <= f_data;
    end
    r_aq <= r_addr;
    f_aq <= f_addr;
  end
  assign r_q = r_mem[r_aq];
  assign f_q = f_mem[f_aq];

  dmem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clock(clk), .reset(reset),
    .p0_req(p0_req), .p0_wren(p0_wren), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rvalid), .p0_rdata(r_p0_rdata),
    .p1_req(p1_req), .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rvalid), .p1_rdata(r_p1_rdata),
    .mem_address(r_addr), .mem_data(r_data), .mem_wren(r_wren), .mem_q(r_q)
  );

  dmem_arbiter #(.FIXED_PRIO(1), .MAX_BURST(4)) u_fp (
    .clock(clk), .reset(reset),
    .p0_req(p0_req), .p0_wren(p0_wren), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
    .p1_req(p1_req), .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
    .mem_address(f_addr), .mem_data(f_data), .mem_wren(f_wren), .mem_q(f_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // apply one cycle of requests at the falling edge, then settle before checks
  task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1);
    @(negedge clk);
    p0_req = r0; p0_wren = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_wren = w1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  initial begin
    drive(1, 1, 12'h055, 32'hFFFF0000, 1, 1, 12'h066, 32'h0000FFFF);
    chk("rst_p0_gnt", r_p0_gnt, 0);
    chk("rst_p1_gnt", r_p1_gnt, 0);
    chk("rst_wren", r_wren, 0);
    chk("rst_addr", r_addr, 0);
    chk("rst_data", r_data, 0);
    chk("rst_rvalid", {r_p0_rvalid, r_p1_rvalid, f_p0_rvalid, f_p1_rvalid}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    // round-robin alternation from reset: p0 first
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1, 0, 12'h020, 0, 1, 0, 12'h030, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 6) begin
        chk($sformatf("rr_p0_gnt%0d", i), r_p0_gnt, (i % 2 == 0));
        chk($sformatf("rr_p1_gnt%0d", i), r_p1_gnt, (i % 2 == 1));
        chk($sformatf("rr_addr%0d", i), r_addr, (i % 2 == 0) ? 12'h020 : 12'h030);
      end
      if (i > 0) begin
        chk($sformatf("rr_p0_rv%0d", i), r_p0_rvalid, ((i - 1) % 2 == 0));
        chk($sformatf("rr_p1_rv%0d", i), r_p1_rvalid, ((i - 1) % 2 == 1));
        chk($sformatf("rr_rdata%0d", i), (i % 2 == 1) ? r_p0_rdata : r_p1_rdata,
            (i % 2 == 1) ? 32'h5A5A0020 : 32'h5A5A0030);
      end
    end
    // lone p0 read of the DEADBEEF word
    drive(1, 0, 12'h010, 0, 0, 0, 0, 0);
    chk("t1_p0_gnt", r_p0_gnt, 1);
    chk("t1_p1_gnt", r_p1_gnt, 0);
    chk("t1_addr", r_addr, 12'h010);
    chk("t1_wren", r_wren, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_rvalid", r_p0_rvalid, 1);
    chk("t1_rdata", r_p0_rdata, 32'hDEADBEEF);
    chk("t1_p1_rvalid", r_p1_rvalid, 0);
    // idle cycles; last_gnt stays on p0 so the next tie goes to p1
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("idle_gnt%0d", i), {r_p0_gnt, r_p1_gnt}, 0);
      chk($sformatf("idle_mem%0d", i), {r_wren, r_addr, r_data}, 0);
      chk($sformatf("idle_rv%0d", i), {r_p0_rvalid, r_p1_rvalid, r_p0_rdata}, 0);
    end
    drive(1, 0, 12'h001, 0, 1, 0, 12'h002, 0);
    chk("idle_keep_last", {r_p0_gnt, r_p1_gnt}, 2'b01);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_p1_rdata", r_p1_rdata, 32'h5A5A0002);
    // fixed priority: p0 x4 then p1 x1, repeating
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 12'h040, 0, 1, 0, 12'h041, 0);
      chk($sformatf("fp_p0_gnt%0d", i), f_p0_gnt, (i % 5 != 4));
      chk($sformatf("fp_p1_gnt%0d", i), f_p1_gnt, (i % 5 == 4));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fp_last_rv", {f_p0_rvalid, f_p1_rvalid}, 2'b01);
    chk("fp_last_rdata", f_p1_rdata, 32'h5A5A0041);
    // p1 write then p0 read-after-write to the same word
    drive(0, 0, 0, 0, 1, 1, 12'h0AB, 32'h12345678);
    chk("raw_wr_gnt", r_p1_gnt, 1);
    chk("raw_wr_mem", {r_wren, r_addr, r_data}, {1'b1, 12'h0AB, 32'h12345678});
    drive(1, 0, 12'h0AB, 0, 0, 0, 0, 0);
    chk("raw_rd_gnt", r_p0_gnt, 1);
    chk("raw_no_wr_rv", r_p1_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_rv", r_p0_rvalid, 1);
    chk("raw_rdata", r_p0_rdata, 32'h12345678);
    chk("raw_fp_rdata", f_p0_rdata, 32'h12345678);
    // reset one cycle after a granted read
    drive(1, 0, 12'h010, 0, 0, 0, 0, 0);
    chk("rr_rst_gnt", r_p0_gnt, 1);
    drive(0, 0, 0, 0, 1, 1, 12'h077, 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    chk("rst_mid_rv1", {r_p0_rvalid, f_p0_rvalid}, 0);
    chk("rst_mid_wren", {r_wren, f_wren, r_p1_gnt, f_p1_gnt}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_rv2", {r_p0_rvalid, r_p1_rvalid, f_p0_rvalid}, 0);
    chk("rst_no_write", r_mem[12'h077], 32'h5A5A0077);
    drive(1, 0, 12'h003, 0, 1, 0, 12'h004, 0);
    chk("rst_p0_pref", {r_p0_gnt, r_p1_gnt}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_after_rdata", r_p0_rdata, 32'h5A5A0003);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
